// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small character FIFO feeds a holding register
// through a fetch FSM, and an 8N1-style serializer shifts it out on baud_tick.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  uart_clk,
    input  logic                  uart_rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    input  logic                  baud_tick,
    output logic                  tx_serial,
    output logic                  tx_empty,
    output logic                  tx_active,
    output logic [3:0]            tx_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [3:0]    DEPTH_LVL = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {F_IDLE, F_FETCHING, F_READY} fetch_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [3:0]            count;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  push;
    logic                  pop;

    fetch_state_t          fstate, fstate_nxt;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_valid;
    logic                  accepted;
    logic                  hold_load;
    logic                  set_accept;
    logic                  hold_release;

    tx_state_t             tstate, tstate_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic                  tx_valid;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_full   = (count == DEPTH_LVL);
    assign tx_empty  = (count == 4'd0);
    assign tx_level  = count;
    assign push      = wr_en && !wr_full;
    assign tx_valid  = hold_valid;
    assign tx_active = (tstate != T_IDLE);

    // Popped data lands in pop_data; the fetch FSM moves it to hold_reg a cycle later.
    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            pop_data <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) fstate <= F_IDLE;
        else             fstate <= fstate_nxt;
    end

    always_comb begin
        fstate_nxt   = fstate;
        pop          = 1'b0;
        hold_load    = 1'b0;
        set_accept   = 1'b0;
        hold_release = 1'b0;
        case (fstate)
            F_IDLE: begin
                if (!tx_empty) begin
                    pop        = 1'b1;
                    fstate_nxt = F_FETCHING;
                end
            end
            F_FETCHING: begin
                hold_load  = 1'b1;
                fstate_nxt = F_READY;
            end
            F_READY: begin
                if (tx_active && !accepted) begin
                    set_accept = 1'b1;
                end else if (!tx_active && accepted) begin
                    hold_release = 1'b1;
                    if (!tx_empty) begin
                        pop        = 1'b1;
                        fstate_nxt = F_FETCHING;
                    end else begin
                        fstate_nxt = F_IDLE;
                    end
                end
            end
            default: fstate_nxt = F_IDLE;
        endcase
    end

    // accepted marks that the serializer has latched hold_reg, so the slot can be refilled once the frame ends.
    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            accepted   <= 1'b0;
        end else if (hold_load) begin
            hold_reg   <= pop_data;
            hold_valid <= 1'b1;
            accepted   <= 1'b0;
        end else if (set_accept) begin
            accepted   <= 1'b1;
        end else if (hold_release) begin
            hold_valid <= 1'b0;
            accepted   <= 1'b0;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) tstate <= T_IDLE;
        else             tstate <= tstate_nxt;
    end

    always_comb begin
        tstate_nxt = tstate;
        if (baud_tick) begin
            case (tstate)
                T_IDLE:  if (tx_valid) tstate_nxt = T_START;
                T_START: tstate_nxt = T_DATA;
                T_DATA:  if (bit_cnt == LAST_BIT) tstate_nxt = T_STOP;
                T_STOP:  tstate_nxt = T_IDLE;
                default: tstate_nxt = T_IDLE;
            endcase
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
        end else if (baud_tick) begin
            case (tstate)
                T_IDLE: begin
                    if (tx_valid) begin
                        shift_reg <= hold_reg;
                        tx_serial <= 1'b0;
                    end
                end
                T_START: begin
                    tx_serial <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= '0;
                end
                T_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        tx_serial <= 1'b1;
                    end else begin
                        tx_serial <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: tx_serial <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: baud_tick every 16 cycles, a frame decoder
// samples mid-bit and collects received characters for in-order comparison.
module tb_uart_tx_fifo;

    logic       uart_clk = 1'b0;
    logic       uart_rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       wr_full;
    logic       baud_tick = 1'b0;
    logic       tx_serial;
    logic       tx_empty;
    logic       tx_active;
    logic [3:0] tx_level;

    int n_checks = 0;
    int n_errors = 0;

    bit         tick_en = 1'b0;
    int         tick_cnt = 0;
    logic [7:0] rx_q[$];
    bit         rx_busy = 1'b0;
    int         rx_c = 0;
    logic [7:0] rx_byte = 8'h00;

    uart_tx_fifo #(.FIFO_DEPTH(8), .DATA_WIDTH(8)) dut (
        .uart_clk   (uart_clk),
        .uart_rst_n (uart_rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_full    (wr_full),
        .baud_tick  (baud_tick),
        .tx_serial  (tx_serial),
        .tx_empty   (tx_empty),
        .tx_active  (tx_active),
        .tx_level   (tx_level)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Baud tick: one-cycle pulse every 16 cycles while enabled.
    always @(negedge uart_clk) begin
        if (!tick_en) begin
            tick_cnt  = 0;
            baud_tick = 1'b0;
        end else begin
            baud_tick = (tick_cnt == 15);
            tick_cnt  = (tick_cnt == 15) ? 0 : tick_cnt + 1;
        end
    end

    // Frame decoder: c=0 is the first sample of the start bit, bit k spans c=16k..16k+15.
    always @(negedge uart_clk) begin
        int bi;
        if (!uart_rst_n) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx_active && tx_serial == 1'b0) begin
                rx_busy = 1'b1;
                rx_c    = 0;
            end
        end else begin
            rx_c++;
            if (rx_c >= 24 && rx_c < 152 && (rx_c % 16) == 8) begin
                bi = rx_c / 16 - 1;
                rx_byte[3'(bi)] = tx_serial;
            end
            if (rx_c == 152) begin
                check("stop_bit", tx_serial, 1);
                rx_q.push_back(rx_byte);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge uart_clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int bound);
        int k = 0;
        while (rx_q.size() < n && k < bound) begin
            @(negedge uart_clk);
            k++;
        end
        check("rx_wait", (rx_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_active(input logic lvl, input int bound);
        int k = 0;
        while (tx_active !== lvl && k < bound) begin
            @(negedge uart_clk);
            k++;
        end
        check("active_wait", tx_active, lvl);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((tx_active || !tx_empty) && k < bound) begin
            @(negedge uart_clk);
            k++;
        end
        check("idle_wait", (!tx_active && tx_empty) ? 1 : 0, 1);
        repeat (4) @(negedge uart_clk);
    endtask

    initial begin
        int base;
        int act_cnt;

        repeat (3) @(negedge uart_clk);
        check("rst_serial", tx_serial, 1);
        check("rst_active", tx_active, 0);
        check("rst_level", tx_level, 0);
        check("rst_full", wr_full, 0);
        check("rst_empty", tx_empty, 1);
        uart_rst_n = 1'b1;
        @(negedge uart_clk);

        // Three writes, no ticks: first is fetched while the next two queue.
        write_byte(8'hA3);
        check("lvl_first_write", tx_level, 1);
        write_byte(8'h0F);
        write_byte(8'hFF);
        check("lvl_after_fetch", tx_level, 2);
        check("lvl_empty", tx_empty, 0);
        check("lvl_full", wr_full, 0);
        base = rx_q.size();
        tick_en = 1'b1;
        wait_rx(base + 3, 1200);
        check("seq_byte0", rx_q[base], 8'hA3);
        check("seq_byte1", rx_q[base + 1], 8'h0F);
        check("seq_byte2", rx_q[base + 2], 8'hFF);
        wait_idle(400);
        check("seq_empty", tx_empty, 1);
        check("seq_level", tx_level, 0);

        // 0x55 frame: exact bit timing and activity window.
        base = rx_q.size();
        write_byte(8'h55);
        wait_active(1'b1, 100);
        for (int c = 0; c < 160; c++) begin
            check("b55_serial", tx_serial, (c / 16) % 2);
            check("b55_active", tx_active, 1);
            @(negedge uart_clk);
        end
        check("b55_end_active", tx_active, 0);
        check("b55_end_serial", tx_serial, 1);
        wait_rx(base + 1, 100);
        check("b55_byte", rx_q[base], 8'h55);
        wait_idle(400);
        tick_en = 1'b0;

        // Fill without ticks: 9 accepted (one in holding), 10th dropped.
        base = rx_q.size();
        for (int i = 0; i < 10; i++) begin
            write_byte(8'(8'h10 + i));
            if (i == 7) begin
                check("fill8_level", tx_level, 7);
                check("fill8_full", wr_full, 0);
            end else if (i == 8) begin
                check("fill9_level", tx_level, 8);
                check("fill9_full", wr_full, 1);
            end else if (i == 9) begin
                check("fill10_level", tx_level, 8);
                check("fill10_full", wr_full, 1);
            end
        end
        tick_en = 1'b1;
        wait_rx(base + 9, 2500);
        for (int i = 0; i < 9; i++) check("fill_byte", rx_q[base + i], 8'(8'h10 + i));
        wait_idle(400);
        repeat (200) @(negedge uart_clk);
        check("fill_count", rx_q.size(), base + 9);
        tick_en = 1'b0;

        // Push coinciding with the pop at frame end, level 2.
        base = rx_q.size();
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        check("pp_level_pre", tx_level, 2);
        tick_en = 1'b1;
        wait_active(1'b1, 100);
        wait_active(1'b0, 300);
        write_byte(8'hC4);
        check("pp_level_post", tx_level, 2);
        wait_rx(base + 4, 1200);
        check("pp_byte0", rx_q[base], 8'hC1);
        check("pp_byte1", rx_q[base + 1], 8'hC2);
        check("pp_byte2", rx_q[base + 2], 8'hC3);
        check("pp_byte3", rx_q[base + 3], 8'hC4);
        wait_idle(400);

        // Reset in the middle of data bit 1 with one byte still queued.
        base = rx_q.size();
        write_byte(8'h5A);
        write_byte(8'h77);
        wait_active(1'b1, 100);
        repeat (40) @(negedge uart_clk);
        uart_rst_n = 1'b0;
        @(negedge uart_clk);
        check("mrst_serial", tx_serial, 1);
        check("mrst_active", tx_active, 0);
        check("mrst_level", tx_level, 0);
        check("mrst_empty", tx_empty, 1);
        check("mrst_full", wr_full, 0);
        uart_rst_n = 1'b1;
        act_cnt = 0;
        repeat (400) begin
            @(negedge uart_clk);
            if (tx_active) act_cnt++;
        end
        check("mrst_quiet", act_cnt, 0);
        check("mrst_no_rx", rx_q.size(), base);
        write_byte(8'h3C);
        wait_rx(base + 1, 400);
        check("mrst_new_byte", rx_q[base], 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
